nv_clk_gate_ctrl: RTL and testbench

- Sequencer that drives the enable of a downstream power clock-gate (ICG) cell for one NVDLA sub-unit clock domain.
- Runs on the free-running (ungated) clock. Watches per-requester activity and opens the gate on demand.
- Holds the gate open for a settle window before signalling ready, and closes it after a programmable idle period plus a drain window.
- Provides a software override that forces the clock on.

---
 rtl/nv_clk_gate_ctrl_pkg.sv | 14 +
 rtl/nv_clk_gate_idle_cnt.sv | 30 +++
 rtl/nv_clk_gate_ctrl.sv | 93 +++++++++
 tb/tb_nv_clk_gate_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/nv_clk_gate_ctrl_pkg.sv
// nv_clk_gate_ctrl_pkg: shared types and widths for the clock-gate sequencer.
//   gate_state_e : FSM encoding, also driven on gate_state (OFF=0, WAKE=1, ON=2, DRAIN=3)
//   CNT_W        : width of the wake/drain settle counter
//   STAT_W       : width of the gated-cycle statistics counter
package nv_clk_gate_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_WAKE  = 2'd1,
        ST_ON    = 2'd2,
        ST_DRAIN = 2'd3
    } gate_state_e;
    localparam int CNT_W  = 4;
    localparam int STAT_W = 32;
endpackage

// File: rtl/nv_clk_gate_idle_cnt.sv
// nv_clk_gate_idle_cnt: saturating idle counter with threshold compare.
//   clk, reset_ : free-running clock, async active-low reset
//   clr         : zero the count (activity seen, or not in ON)
//   inc         : count one idle cycle
//   thresh      : idle cycles before gating; 0 never expires
//   expire      : this idle cycle is the last one allowed
module nv_clk_gate_idle_cnt
    import nv_clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_W = 8
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              clr,
    input  logic              inc,
    input  logic [IDLE_W-1:0] thresh,
    output logic              expire
);
    logic [IDLE_W-1:0] idle_cnt;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            idle_cnt <= '0;
        else if (clr)
            idle_cnt <= '0;
        else if (inc && idle_cnt != '1)
            idle_cnt <= idle_cnt + IDLE_W'(1);
    end
    // >= rather than == so a threshold lowered below the running count gates on the next idle cycle
    assign expire = inc && (thresh != '0) && (idle_cnt >= thresh - IDLE_W'(1));
endmodule

// File: rtl/nv_clk_gate_ctrl.sv
// nv_clk_gate_ctrl: sequences the enable of a downstream ICG for one clock domain.
//   clk, reset_    : free-running clock, async active-low reset
//   req            : per-requester activity levels, any bit high = clock needed
//   idle_thresh    : idle cycles in ON before gating; 0 = never gate
//   slcg_override  : force the clock on
//   clk_en         : registered ICG enable
//   clk_rdy        : registered, gated clock is stable and usable
//   gate_state     : current FSM state
//   gated_cycles   : cycles spent in OFF (only with NV_CLK_GATE_CTRL_STAT_EN, else 0)
//   stat_clr       : synchronous clear of gated_cycles
// Build option: define NV_CLK_GATE_CTRL_STAT_EN to include the gated-cycle counter.
module nv_clk_gate_ctrl
    import nv_clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int IDLE_W    = 8,
    parameter int WAKE_CYC  = 2,
    parameter int DRAIN_CYC = 2
) (
    input  logic               clk,
    input  logic               reset_,
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDLE_W-1:0]  idle_thresh,
    input  logic               slcg_override,
    output logic               clk_en,
    output logic               clk_rdy,
    output logic [1:0]         gate_state,
    output logic [STAT_W-1:0]  gated_cycles,
    input  logic               stat_clr
);
    gate_state_e      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             need, expire;
    assign need = |req | slcg_override;
    // override implies need, so the idle counter never advances while it is set
    nv_clk_gate_idle_cnt #(.IDLE_W(IDLE_W)) u_idle (
        .clk    (clk),
        .reset_ (reset_),
        .clr    (state != ST_ON || need),
        .inc    (state == ST_ON && !need),
        .thresh (idle_thresh),
        .expire (expire)
    );
    always_comb begin
        state_d = state;
        cnt_d   = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        case (state)
            ST_OFF: if (need) begin
                state_d = ST_WAKE;
                cnt_d   = CNT_W'(WAKE_CYC - 1);
            end
            ST_WAKE: state_d = (cnt == '0) ? ST_ON : ST_WAKE;
            ST_ON: if (expire) begin
                state_d = ST_DRAIN;
                cnt_d   = CNT_W'(DRAIN_CYC - 1);
            end
            // returning activity beats drain expiry so clk_en never blips low
            ST_DRAIN: state_d = need ? ST_ON : (cnt == '0) ? ST_OFF : ST_DRAIN;
            default: state_d = ST_OFF;
        endcase
    end
    // outputs are registered from next-state so nothing combinational reaches the ICG
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state   <= ST_OFF;
            cnt     <= '0;
            clk_en  <= 1'b0;
            clk_rdy <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            clk_en  <= state_d != ST_OFF;
            clk_rdy <= state_d == ST_ON;
        end
    end
    assign gate_state = state;
`ifdef NV_CLK_GATE_CTRL_STAT_EN
    logic [STAT_W-1:0] stat_q;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_)
            stat_q <= '0;
        else if (stat_clr)
            stat_q <= '0;
        else if (state == ST_OFF && stat_q != '1)
            stat_q <= stat_q + STAT_W'(1);
    end
    assign gated_cycles = stat_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign gated_cycles    = '0;
`endif
endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// tb_nv_clk_gate_ctrl: directed bench for nv_clk_gate_ctrl (WAKE_CYC=2, DRAIN_CYC=2).
module tb_nv_clk_gate_ctrl;
    logic        clk = 1'b0;
    logic        reset_;
    logic [3:0]  req;
    logic [7:0]  idle_thresh;
    logic        slcg_override;
    logic        clk_en;
    logic        clk_rdy;
    logic [1:0]  gate_state;
    logic [31:0] gated_cycles;
    logic        stat_clr;
    int          total = 0;
    int          bad = 0;
    int          good_cyc;

    nv_clk_gate_ctrl dut (
        .clk           (clk),
        .reset_        (reset_),
        .req           (req),
        .idle_thresh   (idle_thresh),
        .slcg_override (slcg_override),
        .clk_en        (clk_en),
        .clk_rdy       (clk_rdy),
        .gate_state    (gate_state),
        .gated_cycles  (gated_cycles),
        .stat_clr      (stat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic en, input logic rdy, input logic [1:0] st);
        chk({tag, "_en"}, {31'd0, clk_en}, {31'd0, en});
        chk({tag, "_rdy"}, {31'd0, clk_rdy}, {31'd0, rdy});
        chk({tag, "_st"}, {30'd0, gate_state}, {30'd0, st});
    endtask

`ifdef NV_CLK_GATE_CTRL_STAT_EN
    localparam logic [31:0] STAT50 = 32'd50;
`else
    localparam logic [31:0] STAT50 = 32'd0;
`endif

    initial begin
        reset_ = 1'b0; req = '0; idle_thresh = 8'd5; slcg_override = 1'b0; stat_clr = 1'b0;
        tick(2);
        outs("reset", 1'b0, 1'b0, 2'd0);
        chk("reset_stat", gated_cycles, 32'd0);
        reset_ = 1'b1;
        tick(50);
        outs("off50", 1'b0, 1'b0, 2'd0);
        chk("stat50", gated_cycles, STAT50);
        stat_clr = 1'b1;
        tick(1);
        stat_clr = 1'b0;
        chk("stat_clr", gated_cycles, 32'd0);
        // wake: enable one cycle after req, ready WAKE_CYC cycles after enable
        req = 4'b0001;
        tick(1); outs("wake1", 1'b1, 1'b0, 2'd1);
        tick(1); outs("wake2", 1'b1, 1'b0, 2'd1);
        tick(1); outs("on", 1'b1, 1'b1, 2'd2);
        tick(3); outs("on_held", 1'b1, 1'b1, 2'd2);
        // idle gate with threshold 5: rdy falls after 5 idle cycles, en 2 later
        req = '0;
        tick(4); outs("idle4", 1'b1, 1'b1, 2'd2);
        tick(1); outs("drain1", 1'b1, 1'b0, 2'd3);
        tick(1); outs("drain2", 1'b1, 1'b0, 2'd3);
        tick(1); outs("gated", 1'b0, 1'b0, 2'd0);
        // drain re-entry: one-cycle pulse in the first DRAIN cycle
        req = 4'b0100;
        tick(3); outs("rewake", 1'b1, 1'b1, 2'd2);
        req = '0;
        tick(5); outs("re_drain", 1'b1, 1'b0, 2'd3);
        req = 4'b1000;
        tick(1); outs("reentry", 1'b1, 1'b1, 2'd2);
        req = '0;
        tick(4); outs("re_idle4", 1'b1, 1'b1, 2'd2);
        tick(1); outs("re_drain2", 1'b1, 1'b0, 2'd3);
        tick(2); outs("re_gated", 1'b0, 1'b0, 2'd0);
        // override holds the clock with no requesters
        idle_thresh = 8'd3; slcg_override = 1'b1; good_cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            tick(1);
            if (i >= 3 && clk_en && clk_rdy) good_cyc++;
        end
        chk("ovr_cycles", good_cyc, 32'd98);
        slcg_override = 1'b0;
        tick(3); outs("ovr_drain", 1'b1, 1'b0, 2'd3);
        tick(2); outs("ovr_gated", 1'b0, 1'b0, 2'd0);
        // never gate, then drop threshold below the saturated count
        idle_thresh = 8'd0; req = 4'b0010;
        tick(1);
        req = '0;
        tick(2); outs("ng_on", 1'b1, 1'b1, 2'd2);
        tick(300); outs("ng_held", 1'b1, 1'b1, 2'd2);
        idle_thresh = 8'd5;
        tick(1); outs("thr_drop", 1'b1, 1'b0, 2'd3);
        tick(2); outs("thr_gated", 1'b0, 1'b0, 2'd0);
        // async reset mid-WAKE
        req = 4'b0001;
        tick(1); outs("pre_rst", 1'b1, 1'b0, 2'd1);
        #2 reset_ = 1'b0;
        #1 outs("async_rst", 1'b0, 1'b0, 2'd0);
        tick(1);
        req = '0; reset_ = 1'b1;
        tick(2); outs("post_rst", 1'b0, 1'b0, 2'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
